// File: rtl/cam_pkg.sv
// cam_pkg: definitions shared by the camshift tracking controller.
//   COORD_W   width of one window coordinate
//   WIN_W     width of a packed search window
//   win_t     packed window {c_min, c_max, r_min, r_max}
//   state_t   one-hot sequencer states
//   clamp_coord  limits one coordinate to an upper bound
package cam_pkg;

  localparam int COORD_W = 11;
  localparam int WIN_W   = 4 * COORD_W;

  // The field order fixes the bus packing:
  // c_min [43:33], c_max [32:22], r_min [21:11], r_max [10:0].
  typedef struct packed {
    logic [COORD_W-1:0] c_min;
    logic [COORD_W-1:0] c_max;
    logic [COORD_W-1:0] r_min;
    logic [COORD_W-1:0] r_max;
  } win_t;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_ARMED  = 6'b000010,
    ST_LAUNCH = 6'b000100,
    ST_WAIT   = 6'b001000,
    ST_CHECK  = 6'b010000,
    ST_LOST   = 6'b100000
  } state_t;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/win_clamp.sv
// win_clamp: combinational legalisation of a search window against the image.
//   win_in   raw window {c_min, c_max, r_min, r_max}
//   win_out  window with every coordinate inside the image and min <= max
// Both ends of an axis are clamped before ordering, so an inverted window
// that lies partly off-image still ends up fully inside it.
module win_clamp
  import cam_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  win_t win_in,
  output win_t win_out
);

  localparam logic [COORD_W-1:0] COL_LIM = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] ROW_LIM = COORD_W'(IMG_H - 1);

  logic [COORD_W-1:0] c_a, c_b, r_a, r_b;

  always_comb begin
    c_a = clamp_coord(win_in.c_min, COL_LIM);
    c_b = clamp_coord(win_in.c_max, COL_LIM);
    r_a = clamp_coord(win_in.r_min, ROW_LIM);
    r_b = clamp_coord(win_in.r_max, ROW_LIM);

    win_out.c_min = (c_a > c_b) ? c_b : c_a;
    win_out.c_max = (c_a > c_b) ? c_a : c_b;
    win_out.r_min = (r_a > r_b) ? r_b : r_a;
    win_out.r_max = (r_a > r_b) ? r_a : r_b;
  end

endmodule

// File: rtl/cam_track_ctrl.sv
// cam_track_ctrl: per-frame sequencer for the camshift tracking engine.
//   clk, rst_n     clock, asynchronous active-low reset
//   track_en       level, tracking enabled
//   frame_start    pulse, new frame available
//   init_valid     pulse, load init_win (clamped to the image)
//   init_win       {c_min, c_max, r_min, r_max}, 11 bits each
//   cam_en         launch pulse to camshift
//   win_o          window presented to camshift
//   w_o, h_o       image size constants
//   cam_done       completion pulse from camshift
//   res_win, cam_s camshift result window and area
//   trk_valid      pulse, accepted result with centre trk_x / trk_y
//   lost           level, target lost after repeated misses
//   busy           a camshift run is in flight (LAUNCH, WAIT, CHECK)
//   ovr_cnt        saturating count of frames dropped while busy
module cam_track_ctrl
  import cam_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int MIN_AREA = 64,
  parameter int TIMEOUT  = 2000000,
  parameter int LOST_MAX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               track_en,
  input  logic               frame_start,
  input  logic               init_valid,
  input  logic [WIN_W-1:0]   init_win,
  output logic               cam_en,
  output logic [WIN_W-1:0]   win_o,
  output logic [COORD_W-1:0] w_o,
  output logic [COORD_W-1:0] h_o,
  input  logic               cam_done,
  input  logic [WIN_W-1:0]   res_win,
  input  logic [21:0]        cam_s,
  output logic               trk_valid,
  output logic [COORD_W-1:0] trk_x,
  output logic [COORD_W-1:0] trk_y,
  output logic               lost,
  output logic               busy,
  output logic [7:0]         ovr_cnt
);

  localparam int                 TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam int                 MISS_W   = $clog2(LOST_MAX + 1);
  localparam logic [MISS_W-1:0]  MISS_LIM = MISS_W'(LOST_MAX);
  localparam logic [21:0]        AREA_MIN = 22'(MIN_AREA);

  state_t state_q, state_d;

  win_t               win_q, pend_win_q, cap_win_q, init_clamped, chk_init_win;
  logic               pend_q, to_q, lost_q, trk_valid_q;
  logic [21:0]        cap_s_q;
  logic [MISS_W-1:0]  miss_q, miss_inc, miss_after;
  logic [TMR_W-1:0]   tmr_q;
  logic [COORD_W-1:0] trk_x_q, trk_y_q;
  logic [7:0]         ovr_q;
  logic [COORD_W:0]   sum_c, sum_r;
  logic               in_run, init_now, init_defer, timeout_hit, chk_miss, chk_init;

  win_clamp #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_win_clamp (
    .win_in  (win_t'(init_win)),
    .win_out (init_clamped)
  );

  // An init arriving while camshift owns the window is parked and applied
  // when CHECK exits, so win_o never moves under an in-flight run.
  assign in_run     = state_q inside {ST_LAUNCH, ST_WAIT, ST_CHECK};
  assign init_now   = init_valid & ~in_run;
  assign init_defer = init_valid & in_run;
  assign chk_init   = (state_q == ST_CHECK) & (pend_q | init_valid);
  assign chk_init_win = init_valid ? init_clamped : pend_win_q;

  // cam_done wins over a timeout landing in the same cycle.
  assign timeout_hit = (state_q == ST_WAIT) & ~cam_done & (tmr_q == TMR_LAST);

  assign chk_miss = to_q | (cap_s_q < AREA_MIN)
                  | (cap_win_q.c_max <= cap_win_q.c_min)
                  | (cap_win_q.r_max <= cap_win_q.r_min);
  assign miss_inc   = (miss_q == MISS_LIM) ? miss_q : miss_q + MISS_W'(1);
  assign miss_after = chk_miss ? miss_inc : '0;

  // Centre is taken from the 12-bit sum so the carry is kept.
  assign sum_c = {1'b0, cap_win_q.c_min} + {1'b0, cap_win_q.c_max};
  assign sum_r = {1'b0, cap_win_q.r_min} + {1'b0, cap_win_q.r_max};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cam_en  = 1'b0;
    busy    = in_run;
    unique case (state_q)
      ST_IDLE: begin
        if (init_valid && track_en) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (init_valid)       state_d = track_en ? ST_ARMED : ST_IDLE;
        else if (!track_en)   state_d = ST_IDLE;
        else if (frame_start) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        cam_en  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cam_done || timeout_hit) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (chk_init)                    state_d = track_en ? ST_ARMED : ST_IDLE;
        else if (miss_after == MISS_LIM) state_d = ST_LOST;
        else if (track_en)               state_d = ST_ARMED;
        else                             state_d = ST_IDLE;
      end
      ST_LOST: begin
        if (init_valid)     state_d = track_en ? ST_ARMED : ST_IDLE;
        else if (!track_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      pend_win_q  <= '0;
      cap_win_q   <= '0;
      pend_q      <= 1'b0;
      to_q        <= 1'b0;
      lost_q      <= 1'b0;
      trk_valid_q <= 1'b0;
      cap_s_q     <= '0;
      miss_q      <= '0;
      tmr_q       <= '0;
      trk_x_q     <= '0;
      trk_y_q     <= '0;
      ovr_q       <= '0;
    end else begin
      trk_valid_q <= 1'b0;

      if (frame_start && in_run && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;

      if (init_now) begin
        win_q  <= init_clamped;
        miss_q <= '0;
        lost_q <= 1'b0;
      end
      if (init_defer) begin
        pend_q     <= 1'b1;
        pend_win_q <= init_clamped;
      end

      unique case (state_q)
        ST_LAUNCH: tmr_q <= '0;
        ST_WAIT: begin
          if (cam_done) begin
            cap_win_q <= win_t'(res_win);
            cap_s_q   <= cam_s;
            to_q      <= 1'b0;
          end else if (timeout_hit) begin
            to_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_CHECK: begin
          pend_q <= 1'b0;
          if (!chk_miss) begin
            trk_valid_q <= 1'b1;
            trk_x_q     <= sum_c[COORD_W:1];
            trk_y_q     <= sum_r[COORD_W:1];
          end
          if (chk_init) begin
            win_q  <= chk_init_win;
            miss_q <= '0;
            lost_q <= 1'b0;
          end else begin
            if (!chk_miss) win_q <= cap_win_q;
            miss_q <= miss_after;
            if (miss_after == MISS_LIM) lost_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign win_o     = win_q;
  assign w_o       = COORD_W'(IMG_W);
  assign h_o       = COORD_W'(IMG_H);
  assign trk_valid = trk_valid_q;
  assign trk_x     = trk_x_q;
  assign trk_y     = trk_y_q;
  assign lost      = lost_q;
  assign ovr_cnt   = ovr_q;

endmodule
